// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : Hardwired Moore control unit for the single-bus Mini SRC datapath;
//            sequences fetch/decode/execute and drives every control strobe.
// Revision : 1.0  initial release
// ============================================================================
module control_sequencer #(
    parameter int MEM_WAIT      = 0,
    parameter bit ILLEGAL_HALTS = 1'b0
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        Run,
    output logic        Illegal,
    output logic [4:0]  CONTROL,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        R_In,
    output logic        R_Out,
    output logic        BA_Out,
    output logic        PC_Out,
    output logic        MDR_Out,
    output logic        ZHI_Out,
    output logic        ZLO_Out,
    output logic        C_Out,
    output logic        PC_In,
    output logic        IncPC,
    output logic        MAR_In,
    output logic        MDR_In,
    output logic        IR_In,
    output logic        Y_In,
    output logic        ZHI_In,
    output logic        ZLO_In,
    output logic        Read,
    output logic        Write
);

    localparam int c_WAIT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(MEM_WAIT);

    localparam logic [4:0] c_OP_LD   = 5'b00000;
    localparam logic [4:0] c_OP_LDI  = 5'b00001;
    localparam logic [4:0] c_OP_ST   = 5'b00010;
    localparam logic [4:0] c_OP_ADD  = 5'b00011;
    localparam logic [4:0] c_OP_AND  = 5'b01001;
    localparam logic [4:0] c_OP_OR   = 5'b01010;
    localparam logic [4:0] c_OP_ADDI = 5'b01011;
    localparam logic [4:0] c_OP_ANDI = 5'b01100;
    localparam logic [4:0] c_OP_ORI  = 5'b01101;
    localparam logic [4:0] c_OP_NOP  = 5'b11001;
    localparam logic [4:0] c_OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        K_ALU  = 3'd0,
        K_IMM  = 3'd1,
        K_LDI  = 3'd2,
        K_LD   = 3'd3,
        K_ST   = 3'd4,
        K_NOP  = 3'd5,
        K_HALT = 3'd6,
        K_ILL  = 3'd7
    } kind_t;

    state_t                r_state;
    logic [c_WAIT_W-1:0]   r_wait;
    logic [4:0]            w_op;
    kind_t                 w_kind;
    logic [4:0]            w_imm_ctl;
    state_t                w_end_state;
    logic                  w_unused;

    assign w_op     = IR[31:27];
    assign w_unused = ^IR[26:0];

    always_comb begin
        w_kind = K_ILL;
        case (w_op)
            c_OP_LD:                        w_kind = K_LD;
            c_OP_LDI:                       w_kind = K_LDI;
            c_OP_ST:                        w_kind = K_ST;
            c_OP_ADDI, c_OP_ANDI, c_OP_ORI: w_kind = K_IMM;
            c_OP_NOP:                       w_kind = K_NOP;
            c_OP_HALT:                      w_kind = K_HALT;
            default: begin
                if (w_op >= c_OP_ADD && w_op <= c_OP_OR)
                    w_kind = K_ALU;
            end
        endcase
    end

    always_comb begin
        w_imm_ctl = c_OP_ADD;
        if (w_op == c_OP_ANDI)
            w_imm_ctl = c_OP_AND;
        else if (w_op == c_OP_ORI)
            w_imm_ctl = c_OP_OR;
    end

    // Stop is only looked at on the last execute edge, so an instruction always completes.
    assign w_end_state = (Stop || w_kind == K_HALT || (w_kind == K_ILL && ILLEGAL_HALTS))
                         ? S_HALT : S_T0;

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state <= S_RST;
            r_wait  <= '0;
        end else begin
            case (r_state)
                S_RST: r_state <= S_T0;
                S_T0: begin
                    r_state <= S_T1;
                    r_wait  <= c_WAIT_LOAD;
                end
                S_T1: begin
                    if (r_wait != '0)
                        r_wait <= r_wait - c_WAIT_W'(1);
                    else
                        r_state <= S_T2;
                end
                S_T2: r_state <= S_T3;
                S_T3: begin
                    if (w_kind == K_NOP || w_kind == K_HALT || w_kind == K_ILL)
                        r_state <= w_end_state;
                    else
                        r_state <= S_T4;
                end
                S_T4: r_state <= S_T5;
                S_T5: begin
                    if (w_kind == K_LD) begin
                        r_state <= S_T6;
                        r_wait  <= c_WAIT_LOAD;
                    end else if (w_kind == K_ST) begin
                        r_state <= S_T6;
                    end else begin
                        r_state <= w_end_state;
                    end
                end
                S_T6: begin
                    if (w_kind == K_ST) begin
                        r_state <= S_T7;
                        r_wait  <= c_WAIT_LOAD;
                    end else if (r_wait != '0) begin
                        r_wait <= r_wait - c_WAIT_W'(1);
                    end else begin
                        r_state <= S_T7;
                    end
                end
                S_T7: begin
                    if (w_kind == K_ST && r_wait != '0)
                        r_wait <= r_wait - c_WAIT_W'(1);
                    else
                        r_state <= w_end_state;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_RST;
            endcase
        end
    end

    always_comb begin
        Run     = 1'b0;
        Illegal = 1'b0;
        CONTROL = 5'b00000;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        R_In    = 1'b0;
        R_Out   = 1'b0;
        BA_Out  = 1'b0;
        PC_Out  = 1'b0;
        MDR_Out = 1'b0;
        ZHI_Out = 1'b0;
        ZLO_Out = 1'b0;
        C_Out   = 1'b0;
        PC_In   = 1'b0;
        IncPC   = 1'b0;
        MAR_In  = 1'b0;
        MDR_In  = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        ZHI_In  = 1'b0;
        ZLO_In  = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        case (r_state)
            S_T0: begin
                Run = 1'b1; PC_Out = 1'b1; MAR_In = 1'b1; IncPC = 1'b1;
            end
            S_T1: begin
                Run = 1'b1; Read = 1'b1; MDR_In = 1'b1;
            end
            S_T2: begin
                Run = 1'b1; MDR_Out = 1'b1; IR_In = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                if (w_kind == K_ILL) begin
                    Illegal = 1'b1;
                end else if (w_kind != K_NOP && w_kind != K_HALT) begin
                    Grb  = 1'b1;
                    Y_In = 1'b1;
                    // ldi/ld/st address via BA_Out so rb==R0 reads as zero
                    if (w_kind == K_ALU || w_kind == K_IMM)
                        R_Out = 1'b1;
                    else
                        BA_Out = 1'b1;
                end
            end
            S_T4: begin
                Run    = 1'b1;
                ZLO_In = 1'b1;
                if (w_kind == K_ALU) begin
                    Grc = 1'b1; R_Out = 1'b1; ZHI_In = 1'b1; CONTROL = w_op;
                end else begin
                    C_Out   = 1'b1;
                    CONTROL = (w_kind == K_IMM) ? w_imm_ctl : c_OP_ADD;
                end
            end
            S_T5: begin
                Run     = 1'b1;
                ZLO_Out = 1'b1;
                if (w_kind == K_LD || w_kind == K_ST) begin
                    MAR_In = 1'b1;
                end else begin
                    Gra = 1'b1; R_In = 1'b1;
                end
            end
            S_T6: begin
                Run    = 1'b1;
                MDR_In = 1'b1;
                if (w_kind == K_ST) begin
                    Gra = 1'b1; R_Out = 1'b1;
                end else begin
                    Read = 1'b1;
                end
            end
            S_T7: begin
                Run = 1'b1;
                if (w_kind == K_ST) begin
                    Write = 1'b1;
                end else begin
                    MDR_Out = 1'b1; Gra = 1'b1; R_In = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
